// File: rtl/sr_pkg.sv
// Shared types and constants for the sr_latch drive controller.
package sr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } sr_state_t;

  localparam logic CMD_SET = 1'b1;
  localparam logic CMD_CLR = 1'b0;

endpackage

// File: rtl/sr_drive_ctrl_sync2.sv
// Two-flop synchronizer, asynchronous active-low reset to 0.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= d;
      r_q    <= r_meta;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/sr_drive_ctrl.sv
// Turns set/clear commands into fixed-width s/r pulses plus a dead-time gap,
// then checks the synchronized latch readback against the commanded value.
module sr_drive_ctrl
  import sr_pkg::*;
#(
  parameter int PULSE_W = 4,
  parameter int GAP_W   = 2,
  parameter int CW      = $clog2(((PULSE_W > GAP_W) ? PULSE_W : GAP_W) + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic q_now,
  output logic done,
  output logic err,
  input  logic err_clr
);

  sr_state_t     r_state;
  sr_state_t     w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          r_dir;
  logic          w_dir_nxt;
  logic          w_finish;
  logic          w_cnt_zero;
  logic          w_q_now;
  logic          r_s;
  logic          r_r;
  logic          r_done;
  logic          r_err;

  sync2 u_sync2 (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (q_fb),
    .q     (w_q_now)
  );

  assign w_cnt_zero = (r_cnt == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_dir_nxt   = r_dir;
    w_finish    = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid) begin
          w_dir_nxt   = cmd_set;
          w_cnt_nxt   = CW'(PULSE_W - 1);
          w_state_nxt = PULSE;
        end
      end
      PULSE: begin
        if (w_cnt_zero) begin
          w_cnt_nxt   = CW'(GAP_W - 1);
          w_state_nxt = GAP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      GAP: begin
        if (w_cnt_zero) begin
          w_finish    = 1'b1;
          w_state_nxt = IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_dir   <= w_dir_nxt;
    end
  end

  // s/r are decoded from the next state so they are registered and can never
  // be high together: only one of them follows the captured direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s    <= 1'b0;
      r_r    <= 1'b0;
      r_done <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_s    <= (w_state_nxt == PULSE) && (w_dir_nxt == CMD_SET);
      r_r    <= (w_state_nxt == PULSE) && (w_dir_nxt == CMD_CLR);
      r_done <= w_finish;
      if (w_finish && (w_q_now != r_dir)) begin
        r_err <= 1'b1;
      end else if (err_clr) begin
        r_err <= 1'b0;
      end
    end
  end

  assign cmd_ready = (r_state == IDLE);
  assign s         = r_s;
  assign r         = r_r;
  assign q_now     = w_q_now;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: doc/sr_drive_ctrl.md
# sr_drive_ctrl

Clocked driver that sits directly upstream of the gate-level `sr_latch`. It turns single set/clear commands from synchronous logic into clean `s`/`r` pulses of fixed width, followed by a dead-time gap. It guarantees `s` and `r` are never high together, reads back the latch `q` through a synchronizer, and flags when the latch did not take the commanded value.

## Interface
Parameters:
- `PULSE_W`, default 4: cycles `s` or `r` is held high; legal range ≥1.
- `GAP_W`, default 2: dead cycles after the pulse before readback check; legal range ≥2, which covers synchronizer latency.
- `CW`, default `$clog2(max(PULSE_W,GAP_W)+1)`: width of the internal down-counter.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous active-low reset.
- `cmd_valid` in 1: command present.
- `cmd_set` in 1: 1 = set latch (`q`=1), 0 = clear latch (`q`=0).
- `cmd_ready` out 1: block can accept a command.
- `s` out 1: latch set drive, registered.
- `r` out 1: latch reset drive, registered.
- `q_fb` in 1: latch `q`; asynchronous to `clk`.
- `q_now` out 1: synchronized `q_fb`.
- `done` out 1: one-cycle pulse when a command completes.
- `err` out 1: sticky readback mismatch flag.
- `err_clr` in 1: clears `err`.

## Operation
- Reset values: `s`=0, `r`=0, `cmd_ready`=1, `done`=0, `err`=0, `q_now`=0, state IDLE, counter 0.
- FSM has three states: IDLE, PULSE, GAP.
- **IDLE**
  - `cmd_ready`=1 and `s`=`r`=0.
  - Accept when `cmd_valid && cmd_ready` at a clock edge: capture `dir`=`cmd_set`, load counter `PULSE_W-1`, go to PULSE.
  - `cmd_set` is ignored when `cmd_valid`=0.
- **PULSE**
  - `s`=`dir` and `r`=`~dir`; `cmd_ready`=0.
  - Counter decrements each cycle.
  - At count 0: load `GAP_W-1`, go to GAP.
- **GAP**
  - `s`=`r`=0 and `cmd_ready`=0.
  - At count 0:
    - Compare `q_now` against `dir`.
    - Assert `done` for one cycle.
    - Set `err` if they differ.
    - Return to IDLE.
- Invariant: `s & r` is never 1, in any state or cycle, including reset.
- A command equal to the current latch state is still fully executed; there is no skip.
- `err`: set on mismatch and held until `err_clr`. If set and clear happen in the same cycle, set wins.
- Commands presented while `cmd_ready`=0 are not captured. The upstream source holds `cmd_valid` and its data stable until accepted.
- Reset asserted mid-operation: `s`/`r` drop to 0 immediately (asynchronously), `done` is not issued, and the command is lost. The latch holds its last state.

## Timing
- Command accepted at edge N.
- `s` or `r` is high after edges N … N+PULSE_W−1, i.e. exactly `PULSE_W` cycles.
- Both are low from edge N+PULSE_W; the gap lasts `GAP_W` cycles.
- `done`=1 and `cmd_ready`=1 after edge N+PULSE_W+GAP_W. `done` is low again after the next edge.
- Earliest next accept is edge N+PULSE_W+GAP_W+1. Throughput is one command per `PULSE_W+GAP_W+1` cycles (7 at defaults).
- `q_now` lags `q_fb` by 2 edges (two-flop synchronizer).

## Structure
- Package `sr_pkg` holds:
  - state enum typedef `sr_state_t` {IDLE, PULSE, GAP};
  - constants `CMD_SET`=1'b1 and `CMD_CLR`=1'b0.
- One sub-module, `sync2`: a two-flop synchronizer with async active-low reset to 0. It is used for `q_fb` → `q_now`.
- `sr_drive_ctrl` contains the FSM, counter, `dir` register and `err` logic. The testbench instantiates `sr_latch` driven by `s`/`r`, with its `q` fed to `q_fb`.

## Test plan
- Reset, then set: with rst_n low→high and `cmd_valid`=1, `cmd_set`=1 for one accept → `s` high exactly 4 cycles, `r`=0 throughout, `done` at accept+6, `q_now`=1, `err`=0.
- Clear after set: set then `cmd_set`=0 → `r` high 4 cycles, `q_now`=0, commands spaced exactly 7 cycles apart with `cmd_valid` held high continuously.
- Backpressure: `cmd_valid` asserted during PULSE with `cmd_set` toggling → not captured; the value present at the cycle `cmd_ready`=1 is the one executed.
- Readback fault: force `q_fb`=0 during a set command → `err`=1 after `done`; `err_clr` pulse → `err`=0. A second mismatch with `err_clr` high on the same cycle → `err` stays 1.
- Reset mid-PULSE: rst_n low at accept+2 → `s`=`r`=0 immediately, `cmd_ready`=1, no `done`. The latch `q` retains its previous value.
- Assertion over all tests: `!(s && r)` every cycle. Also rerun with `PULSE_W`=1, `GAP_W`=2 → 1-cycle pulse, `done` at accept+3.
